// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types for the key-matrix scanner.
// FSM state, event bundle, single-active-bit helper.
package keypad_pkg;

  typedef enum logic {
    ST_SCAN,
    ST_HELD
  } state_e;

  localparam int EVT_CODE_W = 6;

  typedef struct packed {
    logic [EVT_CODE_W-1:0] code;
    logic                  press;
    logic                  rpt;
  } evt_t;

  // true when exactly one bit of v is set
  function automatic logic onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/keypad_row_sampler.sv
// keypad_row_sampler: row synchroniser, ghost reject, press debounce.
// in: clk, reset, row_n, en | out: rows_sync, accept, row_idx
module keypad_row_sampler
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS       = 4,
  parameter int STABLE_SAMPLES = 10,
  parameter int ROW_W          = $clog2(NUM_ROWS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  input  logic                en,
  output logic [NUM_ROWS-1:0] rows_sync,
  output logic                accept,
  output logic [ROW_W-1:0]    row_idx
);

  localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_SAMPLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SAMPLES - 1);

  logic [NUM_ROWS-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_ROWS-1:0] low;
  logic                prev_ok_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                match;

  assign rows_sync = sync2_q;

  always_comb begin
    low = ~sync2_q;
    // the first sample of a window has no predecessor to match
    match = en && prev_ok_q && onehot(8'(low))
            && (sync2_q == prev_q);
    cnt_d = '0;
    if (match) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    accept = match && (cnt_q >= CNT_ACC);
    row_idx = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!sync2_q[i]) row_idx = ROW_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      prev_q    <= '1;
      prev_ok_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= row_n;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      prev_ok_q <= en;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: NxM key matrix scan, debounce, event port.
// in: clk, reset, row_n, evt_ready | out: col_n, evt_*, key_down, overflow
// Optional auto-repeat is built when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int SETTLE_CYCLES  = 100,
  parameter int DWELL_CYCLES   = 10000,
  parameter int STABLE_SAMPLES = 10,
  parameter int RELEASE_CYCLES = 10000,
  parameter int REPEAT_DELAY   = 50_000_000,
  parameter int REPEAT_PERIOD  = 10_000_000,
  parameter int CODE_W         = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CODE_W-1:0]   evt_code,
  output logic                evt_press,
  output logic                evt_repeat,
  output logic                key_down,
  output logic                overflow
);

  localparam int ROW_W   = $clog2(NUM_ROWS);
  localparam int COL_W   = $clog2(NUM_COLS);
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam int REL_W   = $clog2(RELEASE_CYCLES + 1);
  localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE_CYCLES);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [REL_W-1:0]    rel_q, rel_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CODE_W-1:0]   code_q, code_d, code_now;
  logic                key_down_q, key_down_d;
  logic [NUM_COLS-1:0] col_n_q, col_n_d;
  evt_t                evt_q, evt_d, new_ev;
  logic                evt_valid_q, evt_valid_d;
  logic                overflow_q, overflow_d;
  logic                new_evt, en, accept, held_hi;
  logic [ROW_W-1:0]    row_idx;
  logic [NUM_ROWS-1:0] rows_sync;
  logic                unused_evt_bits;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                           REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_lim;
  logic             rpt_first_q, rpt_first_d;
`else
  localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  keypad_row_sampler #(
    .NUM_ROWS      (NUM_ROWS),
    .STABLE_SAMPLES(STABLE_SAMPLES),
    .ROW_W         (ROW_W)
  ) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .row_n    (row_n),
    .en       (en),
    .rows_sync(rows_sync),
    .accept   (accept),
    .row_idx  (row_idx)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    rel_d       = rel_q;
    row_d       = row_q;
    code_d      = code_q;
    key_down_d  = key_down_q;
    evt_d       = evt_q;
    evt_valid_d = evt_valid_q;
    overflow_d  = overflow_q;
    new_evt     = 1'b0;
    new_ev      = '0;
    en = (state_q == ST_SCAN) &&
         (dwell_q >= DWELL_W'(SETTLE_CYCLES));
    code_now = CODE_W'(col_q) * CODE_W'(NUM_ROWS)
               + CODE_W'(row_idx);
    held_hi = rows_sync[row_q];
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_lim     = rpt_first_q ? RPT_W'(REPEAT_DELAY - 1)
                              : RPT_W'(REPEAT_PERIOD - 1);
`endif
    unique case (state_q)
      ST_SCAN: begin
        rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = '0;
        rpt_first_d = 1'b1;
`endif
        // accept ends the dwell early; the column stays driven
        if (accept) begin
          new_evt    = 1'b1;
          new_ev     = '{EVT_CODE_W'(code_now), 1'b1, 1'b0};
          code_d     = code_now;
          row_d      = row_idx;
          key_down_d = 1'b1;
          state_d    = ST_HELD;
        end else if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
          dwell_d = '0;
          col_d   = (col_q == COL_W'(NUM_COLS - 1)) ?
                    '0 : col_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_HELD: begin
        // only the held key's row matters; others are ignored
        if (held_hi) begin
          rel_d = (rel_q == REL_MAX) ? rel_q : rel_q + 1'b1;
        end else begin
          rel_d = '0;
        end
        if (held_hi && rel_q == REL_W'(RELEASE_CYCLES - 1)) begin
          new_evt    = 1'b1;
          new_ev     = '{EVT_CODE_W'(code_q), 1'b0, 1'b0};
          key_down_d = 1'b0;
          state_d    = ST_SCAN;
          col_d      = '0;
          dwell_d    = '0;
          rel_d      = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rpt_q == rpt_lim) begin
          new_evt     = 1'b1;
          new_ev      = '{EVT_CODE_W'(code_q), 1'b1, 1'b1};
          rpt_d       = '0;
          rpt_first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
`endif
      end
      default: ;
    endcase
    col_n_d = ~(NUM_COLS'(1) << col_d);
    // a new event wins over a same-cycle transfer
    if (new_evt) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_d       = new_ev;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      col_q       <= '0;
      dwell_q     <= '0;
      rel_q       <= '0;
      row_q       <= '0;
      code_q      <= '0;
      key_down_q  <= 1'b0;
      col_n_q     <= '1;
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      rel_q       <= rel_d;
      row_q       <= row_d;
      code_q      <= code_d;
      key_down_q  <= key_down_d;
      col_n_q     <= col_n_d;
      evt_q       <= evt_d;
      evt_valid_q <= evt_valid_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
  assign evt_repeat = evt_q.rpt;
`else
  assign evt_repeat = 1'b0;
`endif

  assign col_n     = col_n_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_q.code[CODE_W-1:0];
  assign evt_press = evt_q.press;
  assign key_down  = key_down_q;
  assign overflow  = overflow_q;
  assign unused_evt_bits = ^{evt_q.code, evt_q.rpt};

endmodule
